// File: rtl/rr_burst_arbiter_pkg.sv
// Shared types for the round-robin burst arbiter.
package rr_burst_arbiter_pkg;

  // Burst sequencer states.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_e;

endpackage

// File: rtl/rr_burst_arbiter_arb.sv
// Combinational one-hot round-robin priority arbiter.
// Winner is the first set req bit at or above the one-hot base, wrapping.
module rr_burst_arbiter_arb #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] req,
  input  logic [WIDTH-1:0] base,
  output logic [WIDTH-1:0] gnt
);

  logic [2*WIDTH-1:0] req_dbl;
  logic [2*WIDTH-1:0] gnt_dbl;

  // Doubled-vector borrow trick: subtracting base clears everything up to
  // and including the first requester at or above base; the wrap half covers
  // requesters below base.
  always_comb begin
    req_dbl = {req, req};
    gnt_dbl = req_dbl & ~(req_dbl - {{WIDTH{1'b0}}, base});
    gnt     = gnt_dbl[WIDTH-1:0] | gnt_dbl[2*WIDTH-1:WIDTH];
  end

endmodule

// File: rtl/rr_burst_arbiter.sv
// Registered burst-level round-robin stream multiplexer.
// A grant is held for a whole burst; priority rotates past the winner on release.
module rr_burst_arbiter
  import rr_burst_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 16
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [WIDTH-1:0]            REQ,
  input  logic [WIDTH-1:0]            VALID,
  input  logic [WIDTH*DATA_WIDTH-1:0] DATA,
  input  logic [WIDTH-1:0]            LAST,
  output logic [WIDTH-1:0]            ACK,
  output logic [WIDTH-1:0]            GRANT,
  output logic                        OUT_VALID,
  output logic [DATA_WIDTH-1:0]       OUT_DATA,
  output logic                        OUT_LAST,
  input  logic                        OUT_READY,
  output logic                        BUSY
);

  localparam int unsigned CNT_W = (MAX_BURST == 0) ? 1 : $clog2(MAX_BURST + 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   grant_q, grant_d;
  logic [WIDTH-1:0]   base_q, base_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   arb_gnt;
  logic [WIDTH-1:0]   base_rot;
  logic               granted_last;
  logic               forced_last;
  logic               xfer;
  logic               withdraw;

  rr_burst_arbiter_arb #(.WIDTH(WIDTH)) u_arb (
    .req  (REQ),
    .base (base_q),
    .gnt  (arb_gnt)
  );

  // Next base: current grant rotated left by one, top bit wrapping to bit 0.
  always_comb begin
    base_rot = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      base_rot[(i + 1) % WIDTH] = grant_q[i];
    end
  end

  // AND-OR output mux over the one-hot grant; all zero when idle.
  always_comb begin
    OUT_DATA     = '0;
    OUT_VALID    = |(VALID & grant_q);
    granted_last = |(LAST & grant_q);
    withdraw     = ~|(REQ & grant_q) & ~OUT_VALID;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      OUT_DATA = OUT_DATA | (DATA[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant_q[i]}});
    end
    forced_last = (|grant_q) && (MAX_BURST != 0) && (32'(count_q) == MAX_BURST - 1);
    OUT_LAST    = (|grant_q) & (granted_last | forced_last);
    xfer        = OUT_VALID & OUT_READY;
    ACK         = xfer ? grant_q : '0;
    GRANT       = grant_q;
    BUSY        = |grant_q;
  end

  // Burst sequencer next-state: arbitrate in IDLE, count and release in XFER.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    base_d  = base_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (|REQ) begin
          grant_d = arb_gnt;
          count_d = '0;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (xfer) begin
          count_d = count_q + CNT_W'(1);
        end
        if ((xfer && OUT_LAST) || withdraw) begin
          state_d = ST_IDLE;
          grant_d = '0;
          base_d  = base_rot;
          count_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State registers with synchronous reset; requester 0 has first priority.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      base_q  <= WIDTH'(1);
      count_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      base_q  <= base_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Directed self-checking bench for rr_burst_arbiter (WIDTH=4, MAX_BURST=16).
module tb_rr_burst_arbiter;

  localparam int W  = 4;
  localparam int DW = 32;
  localparam int MB = 16;

  logic            CLK;
  logic            RST;
  logic [W-1:0]    REQ;
  logic [W-1:0]    VALID;
  logic [W*DW-1:0] DATA;
  logic [W-1:0]    LAST;
  logic [W-1:0]    ACK;
  logic [W-1:0]    GRANT;
  logic            OUT_VALID;
  logic [DW-1:0]   OUT_DATA;
  logic            OUT_LAST;
  logic            OUT_READY;
  logic            BUSY;

  int n_checks = 0;
  int n_fail   = 0;

  rr_burst_arbiter #(.WIDTH(W), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ       (REQ),
    .VALID     (VALID),
    .DATA      (DATA),
    .LAST      (LAST),
    .ACK       (ACK),
    .GRANT     (GRANT),
    .OUT_VALID (OUT_VALID),
    .OUT_DATA  (OUT_DATA),
    .OUT_LAST  (OUT_LAST),
    .OUT_READY (OUT_READY),
    .BUSY      (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] pat(input int i, input int n);
    return 32'hD000_0000 | (32'(i) << 8) | 32'(n);
  endfunction

  task automatic drive_words(input int n);
    for (int i = 0; i < W; i++) DATA[i*DW +: DW] = pat(i, n);
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    RST = 1'b1; REQ = 4'hF; VALID = 4'hF; LAST = 4'h0; OUT_READY = 1'b1;
    drive_words(0);
    tick; tick; #1;
    n_checks++; if (GRANT !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b expected %b", GRANT, 4'b0000); end
    n_checks++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", OUT_VALID); end
    n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
    n_checks++; if (ACK !== 4'b0000) begin n_fail++; $display("FAIL reset_ack: got %b expected 0000", ACK); end
    n_checks++; if (OUT_DATA !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0", OUT_DATA); end
    n_checks++; if (OUT_LAST !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %b expected 0", OUT_LAST); end
    RST = 1'b0; VALID = 4'h0;
    tick;
    n_checks++; if (GRANT !== 4'b0001) begin n_fail++; $display("FAIL reset_first_grant: got %b expected 0001", GRANT); end
    n_checks++; if (BUSY !== 1'b1) begin n_fail++; $display("FAIL reset_first_busy: got %b expected 1", BUSY); end
  endtask

  // Enters with requester 0 already granted and REQ=1111.
  task automatic test_round_robin;
    logic [W-1:0] exp;
    for (int k = 0; k < 5; k++) begin
      exp = 4'(1 << (k % 4));
      n_checks++; if (GRANT !== exp) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b expected %b", k, GRANT, exp); end
      for (int w = 0; w < 2; w++) begin
        VALID = exp; LAST = (w == 1) ? exp : 4'h0; drive_words(10 + w);
        #1;
        n_checks++; if (ACK !== exp) begin n_fail++; $display("FAIL rr_ack[%0d.%0d]: got %b expected %b", k, w, ACK, exp); end
        n_checks++; if (OUT_DATA !== pat(k % 4, 10 + w)) begin n_fail++; $display("FAIL rr_data[%0d.%0d]: got %h expected %h", k, w, OUT_DATA, pat(k % 4, 10 + w)); end
        n_checks++; if (OUT_LAST !== (w == 1)) begin n_fail++; $display("FAIL rr_last[%0d.%0d]: got %b expected %b", k, w, OUT_LAST, (w == 1)); end
        tick;
      end
      VALID = 4'h0; LAST = 4'h0;
      if (k == 4) REQ = 4'h0;
      #1;
      n_checks++; if (GRANT !== 4'b0000) begin n_fail++; $display("FAIL rr_dead[%0d]: got %b expected 0000", k, GRANT); end
      tick;
    end
    n_checks++; if (GRANT !== 4'b0000) begin n_fail++; $display("FAIL rr_idle_noreq: got %b expected 0000", GRANT); end
  endtask

  // Base is 0010 on entry.
  task automatic test_wrap;
    REQ = 4'b0100;
    tick;
    n_checks++; if (GRANT !== 4'b0100) begin n_fail++; $display("FAIL wrap_g2: got %b expected 0100", GRANT); end
    VALID = 4'b0100; LAST = 4'b0100; drive_words(7);
    #1;
    n_checks++; if (ACK !== 4'b0100) begin n_fail++; $display("FAIL wrap_ack2: got %b expected 0100", ACK); end
    n_checks++; if (OUT_DATA !== pat(2, 7)) begin n_fail++; $display("FAIL wrap_data2: got %h expected %h", OUT_DATA, pat(2, 7)); end
    tick;
    REQ = 4'b0011; VALID = 4'h0; LAST = 4'h0;
    #1;
    n_checks++; if (GRANT !== 4'b0000) begin n_fail++; $display("FAIL wrap_dead: got %b expected 0000", GRANT); end
    tick;
    n_checks++; if (GRANT !== 4'b0001) begin n_fail++; $display("FAIL wrap_g0: got %b expected 0001", GRANT); end
    VALID = 4'b0001; LAST = 4'b0001;
    #1;
    n_checks++; if (ACK !== 4'b0001) begin n_fail++; $display("FAIL wrap_ack0: got %b expected 0001", ACK); end
    tick;
    VALID = 4'h0; LAST = 4'h0;
    tick;
    n_checks++; if (GRANT !== 4'b0010) begin n_fail++; $display("FAIL wrap_g1: got %b expected 0010", GRANT); end
    VALID = 4'b0010; LAST = 4'b0010;
    #1;
    n_checks++; if (ACK !== 4'b0010) begin n_fail++; $display("FAIL wrap_ack1: got %b expected 0010", ACK); end
    tick;
    REQ = 4'h0; VALID = 4'h0; LAST = 4'h0;
    tick;
  endtask

  // Base is 0100 on entry.
  task automatic test_max_burst;
    logic [W-1:0] seq [4];
    seq[0] = 4'b0100; seq[1] = 4'b1000; seq[2] = 4'b0001; seq[3] = 4'b0010;
    REQ = 4'b0010;
    tick;
    n_checks++; if (GRANT !== 4'b0010) begin n_fail++; $display("FAIL max_grant: got %b expected 0010", GRANT); end
    VALID = 4'hF; LAST = 4'b1101;
    for (int j = 0; j < MB; j++) begin
      drive_words(j);
      #1;
      n_checks++; if (ACK !== 4'b0010) begin n_fail++; $display("FAIL max_ack[%0d]: got %b expected 0010", j, ACK); end
      n_checks++; if (OUT_DATA !== pat(1, j)) begin n_fail++; $display("FAIL max_data[%0d]: got %h expected %h", j, OUT_DATA, pat(1, j)); end
      n_checks++; if (OUT_LAST !== (j == MB - 1)) begin n_fail++; $display("FAIL max_last[%0d]: got %b expected %b", j, OUT_LAST, (j == MB - 1)); end
      tick;
    end
    REQ = 4'hF; LAST = 4'hF;
    #1;
    n_checks++; if (GRANT !== 4'b0000) begin n_fail++; $display("FAIL max_release: got %b expected 0000", GRANT); end
    tick;
    for (int s = 0; s < 4; s++) begin
      n_checks++; if (GRANT !== seq[s]) begin n_fail++; $display("FAIL max_order[%0d]: got %b expected %b", s, GRANT, seq[s]); end
      n_checks++; if (ACK !== seq[s]) begin n_fail++; $display("FAIL max_order_ack[%0d]: got %b expected %b", s, ACK, seq[s]); end
      tick;
      if (s == 3) REQ = 4'h0;
      tick;
    end
    VALID = 4'h0; LAST = 4'h0;
  endtask

  // Base is 0100 on entry.
  task automatic test_backpressure;
    int w;
    int c;
    REQ = 4'b1000; VALID = 4'h0;
    tick;
    n_checks++; if (GRANT !== 4'b1000) begin n_fail++; $display("FAIL bp_grant: got %b expected 1000", GRANT); end
    w = 0;
    c = 0;
    while (w < 4 && c < 20) begin
      OUT_READY = (c % 2 == 0);
      VALID = 4'b1000; LAST = (w == 3) ? 4'b1000 : 4'h0; drive_words(20 + w);
      #1;
      n_checks++; if (ACK !== (OUT_READY ? 4'b1000 : 4'b0000)) begin n_fail++; $display("FAIL bp_ack[c%0d]: got %b expected %b", c, ACK, (OUT_READY ? 4'b1000 : 4'b0000)); end
      n_checks++; if (OUT_DATA !== pat(3, 20 + w)) begin n_fail++; $display("FAIL bp_data[c%0d]: got %h expected %h", c, OUT_DATA, pat(3, 20 + w)); end
      n_checks++; if (GRANT !== 4'b1000) begin n_fail++; $display("FAIL bp_hold[c%0d]: got %b expected 1000", c, GRANT); end
      if (OUT_READY) w++;
      c++;
      tick;
    end
    n_checks++; if (c !== 7) begin n_fail++; $display("FAIL bp_cycles: got %0d expected 7", c); end
    REQ = 4'h0; VALID = 4'h0; LAST = 4'h0; OUT_READY = 1'b1;
    #1;
    n_checks++; if (GRANT !== 4'b0000) begin n_fail++; $display("FAIL bp_release: got %b expected 0000", GRANT); end
    tick;
  endtask

  // Base is 0001 on entry.
  task automatic test_withdraw_reset;
    REQ = 4'b1000;
    tick;
    n_checks++; if (GRANT !== 4'b1000) begin n_fail++; $display("FAIL wd_grant: got %b expected 1000", GRANT); end
    tick;
    n_checks++; if (GRANT !== 4'b1000) begin n_fail++; $display("FAIL wd_bubble_hold: got %b expected 1000", GRANT); end
    REQ = 4'h0; VALID = 4'b1000; drive_words(9);
    #1;
    n_checks++; if (ACK !== 4'b1000) begin n_fail++; $display("FAIL wd_late_ack: got %b expected 1000", ACK); end
    n_checks++; if (OUT_DATA !== pat(3, 9)) begin n_fail++; $display("FAIL wd_late_data: got %h expected %h", OUT_DATA, pat(3, 9)); end
    tick;
    n_checks++; if (GRANT !== 4'b1000) begin n_fail++; $display("FAIL wd_valid_hold: got %b expected 1000", GRANT); end
    VALID = 4'h0;
    tick;
    n_checks++; if (GRANT !== 4'b0000) begin n_fail++; $display("FAIL wd_release: got %b expected 0000", GRANT); end
    REQ = 4'hF;
    tick;
    n_checks++; if (GRANT !== 4'b0001) begin n_fail++; $display("FAIL wd_base: got %b expected 0001", GRANT); end
    VALID = 4'b0001; LAST = 4'h0;
    #1;
    n_checks++; if (ACK !== 4'b0001) begin n_fail++; $display("FAIL rst_pre_ack: got %b expected 0001", ACK); end
    tick;
    RST = 1'b1;
    tick;
    n_checks++; if (GRANT !== 4'b0000) begin n_fail++; $display("FAIL rst_mid_grant: got %b expected 0000", GRANT); end
    n_checks++; if (OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b expected 0", OUT_VALID); end
    n_checks++; if (ACK !== 4'b0000) begin n_fail++; $display("FAIL rst_mid_ack: got %b expected 0000", ACK); end
    RST = 1'b0;
    tick;
    n_checks++; if (GRANT !== 4'b0001) begin n_fail++; $display("FAIL rst_regrant: got %b expected 0001", GRANT); end
    REQ = 4'h0; VALID = 4'h0;
  endtask

  initial begin
    RST = 1'b1; REQ = '0; VALID = '0; LAST = '0; DATA = '0; OUT_READY = 1'b1;
    test_reset;
    test_round_robin;
    test_wrap;
    test_max_burst;
    test_backpressure;
    test_withdraw_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
